// File: rtl/cci_mmio_rsp_arb.sv
// cci_mmio_rsp_arb: merges MMIO read responses from several sources onto the
// single CCI-P c2Tx channel. The channel has no backpressure, so each source
// gets its own FIFO, and a round-robin arbiter drains one response per cycle.
module cci_mmio_rsp_arb #(
  parameter int NUM_SOURCES = 2,
  parameter int FIFO_DEPTH  = 64
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic [NUM_SOURCES-1:0]                       src_rdValid,
  input  logic [NUM_SOURCES*9-1:0]                     src_tid,
  input  logic [NUM_SOURCES*64-1:0]                    src_data,
  output logic                                         c2Tx_mmioRdValid,
  output logic [8:0]                                   c2Tx_tid,
  output logic [63:0]                                  c2Tx_data,
  output logic [NUM_SOURCES-1:0]                       fifo_overflow,
  output logic [$clog2(NUM_SOURCES*FIFO_DEPTH+1)-1:0]  rsp_pending
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int SW  = $clog2(NUM_SOURCES);
  localparam int SW1 = SW + 1;
  localparam int PW  = $clog2(NUM_SOURCES*FIFO_DEPTH+1);
  localparam int EW  = 73;  // {tid[8:0], data[63:0]}

  logic [NUM_SOURCES-1:0] empty;
  logic [NUM_SOURCES-1:0] full;
  logic [NUM_SOURCES-1:0] pop;
  logic [NUM_SOURCES-1:0] accept;
  logic [EW-1:0]          head [NUM_SOURCES];

  logic [SW-1:0]  rr_ptr_reg;
  logic [SW-1:0]  rr_ptr_next;
  logic [SW-1:0]  grant_idx;
  logic [SW1-1:0] cand;
  logic           grant_valid;
  logic [PW-1:0]  pending_reg;
  logic [PW-1:0]  pending_next;

  logic           valid_reg;
  logic [8:0]     tid_reg;
  logic [63:0]    data_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SOURCES; gi++) begin : g_fifo
      logic [EW-1:0] mem_reg [FIFO_DEPTH];
      logic [AW:0]   wr_ptr_reg;
      logic [AW:0]   rd_ptr_reg;
      logic          overflow_reg;

      // Extra MSB on the pointers distinguishes full from empty.
      assign empty[gi]  = (wr_ptr_reg == rd_ptr_reg);
      assign full[gi]   = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                          (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
      assign pop[gi]    = grant_valid && (grant_idx == SW'(gi));
      // A full FIFO can still take a write when its head leaves this cycle.
      assign accept[gi] = src_rdValid[gi] && (!full[gi] || pop[gi]);
      assign head[gi]   = mem_reg[rd_ptr_reg[AW-1:0]];
      assign fifo_overflow[gi] = overflow_reg;

      // Response storage; no reset needed since the pointers define validity.
      always_ff @(posedge clk) begin
        if (!reset && accept[gi]) begin
          mem_reg[wr_ptr_reg[AW-1:0]] <= {src_tid[9*gi +: 9], src_data[64*gi +: 64]};
        end
      end

      // Pointer advance and sticky drop flag.
      always_ff @(posedge clk) begin
        if (reset) begin
          wr_ptr_reg   <= '0;
          rd_ptr_reg   <= '0;
          overflow_reg <= 1'b0;
        end else begin
          if (accept[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
          if (pop[gi])    rd_ptr_reg <= rd_ptr_reg + 1'b1;
          if (src_rdValid[gi] && !accept[gi]) overflow_reg <= 1'b1;
        end
      end
    end
  endgenerate

  // Round-robin pick: first non-empty FIFO at or after rr_ptr, wrapping.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_SOURCES; k++) begin
      cand = {1'b0, rr_ptr_reg} + SW1'(k);
      if (cand >= SW1'(NUM_SOURCES)) cand = cand - SW1'(NUM_SOURCES);
      if (!grant_valid && !empty[cand[SW-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[SW-1:0];
      end
    end
  end

  // Pointer moves just past the winner; holds when nothing is granted.
  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (grant_valid) begin
      rr_ptr_next = (grant_idx == SW'(NUM_SOURCES-1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Occupancy: accepted writes in, at most one pop out.
  always_comb begin
    pending_next = pending_reg;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (accept[i]) pending_next = pending_next + 1'b1;
    end
    if (grant_valid) pending_next = pending_next - 1'b1;
  end

  // Output register: popped head goes out; tid/data hold when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg   <= 1'b0;
      tid_reg     <= '0;
      data_reg    <= '0;
      rr_ptr_reg  <= '0;
      pending_reg <= '0;
    end else begin
      valid_reg   <= grant_valid;
      rr_ptr_reg  <= rr_ptr_next;
      pending_reg <= pending_next;
      if (grant_valid) {tid_reg, data_reg} <= head[grant_idx];
    end
  end

  assign c2Tx_mmioRdValid = valid_reg;
  assign c2Tx_tid         = tid_reg;
  assign c2Tx_data        = data_reg;
  assign rsp_pending      = pending_reg;

endmodule

// File: tb/tb_cci_mmio_rsp_arb.sv
// tb_cci_mmio_rsp_arb: table vectors, directed corner sequences and random
// traffic checked against a queue-based reference model of the merger.
module tb_cci_mmio_rsp_arb;

  localparam int N  = 2;
  localparam int D  = 64;
  localparam int PW = $clog2(N*D+1);

  logic            clk;
  logic            reset;
  logic [N-1:0]    src_rdValid;
  logic [N*9-1:0]  src_tid;
  logic [N*64-1:0] src_data;
  logic            c2Tx_mmioRdValid;
  logic [8:0]      c2Tx_tid;
  logic [63:0]     c2Tx_data;
  logic [N-1:0]    fifo_overflow;
  logic [PW-1:0]   rsp_pending;

  cci_mmio_rsp_arb #(.NUM_SOURCES(N), .FIFO_DEPTH(D)) dut (
    .clk              (clk),
    .reset            (reset),
    .src_rdValid      (src_rdValid),
    .src_tid          (src_tid),
    .src_data         (src_data),
    .c2Tx_mmioRdValid (c2Tx_mmioRdValid),
    .c2Tx_tid         (c2Tx_tid),
    .c2Tx_data        (c2Tx_data),
    .fifo_overflow    (fifo_overflow),
    .rsp_pending      (rsp_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: one queue per source plus a rotating priority index.
  logic [72:0]  mq [N][$];
  logic         m_valid;
  logic [8:0]   m_tid;
  logic [63:0]  m_data;
  logic [N-1:0] m_ovf;
  int           m_pend;
  int           m_rr;
  logic [8:0]   obs [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [8:0] t0, input logic [63:0] d0,
                       input logic [8:0] t1, input logic [63:0] d1);
    src_rdValid = v;
    src_tid     = {t1, t0};
    src_data    = {d1, d0};
  endtask

  // One clock edge: advance the model on the inputs seen at the edge, then
  // compare every output 1 time unit later.
  task automatic step();
    logic [72:0] e;
    int g;
    int idx;
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      m_valid = 1'b0; m_tid = '0; m_data = '0; m_ovf = '0; m_rr = 0;
    end else begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        idx = (m_rr + k) % N;
        if (g < 0 && mq[idx].size() > 0) g = idx;
      end
      m_valid = 1'b0;
      if (g >= 0) begin
        e = mq[g].pop_front();
        m_valid = 1'b1;
        m_tid   = e[72:64];
        m_data  = e[63:0];
        m_rr    = (g + 1) % N;
      end
      for (int i = 0; i < N; i++) begin
        if (src_rdValid[i]) begin
          if (mq[i].size() < D) mq[i].push_back({src_tid[9*i +: 9], src_data[64*i +: 64]});
          else m_ovf[i] = 1'b1;
        end
      end
    end
    m_pend = 0;
    for (int i = 0; i < N; i++) m_pend += mq[i].size();
    #1;
    chk("valid",   64'(c2Tx_mmioRdValid), 64'(m_valid));
    chk("tid",     64'(c2Tx_tid),         64'(m_tid));
    chk("data",    c2Tx_data,             m_data);
    chk("ovf",     64'(fifo_overflow),    64'(m_ovf));
    chk("pending", 64'(rsp_pending),      64'(m_pend));
    if (c2Tx_mmioRdValid) obs.push_back(c2Tx_tid);
  endtask

  typedef struct {
    logic        rst;
    logic [1:0]  v;
    logic [8:0]  t0;
    logic [63:0] d0;
    logic [8:0]  t1;
    logic [63:0] d1;
    logic        ev;
    logic [8:0]  et;
    logic [63:0] ed;
    int          ep;
  } vec_t;

  vec_t tbl [10];
  logic [8:0] rr_exp [12];
  logic [1:0] rv;
  int dens;

  initial begin
    // Reset sequence, simultaneous pair, single response, then a pulse
    // that arrives during reset and must be ignored.
    tbl[0] = '{1'b1, 2'b00, 9'h0,  64'h0,         9'h0, 64'h0,    1'b0, 9'h0,  64'h0,         0};
    tbl[1] = '{1'b0, 2'b11, 9'h1,  64'h1111,      9'h2, 64'h2222, 1'b0, 9'h0,  64'h0,         2};
    tbl[2] = '{1'b0, 2'b00, 9'h0,  64'h0,         9'h0, 64'h0,    1'b1, 9'h1,  64'h1111,      1};
    tbl[3] = '{1'b0, 2'b00, 9'h0,  64'h0,         9'h0, 64'h0,    1'b1, 9'h2,  64'h2222,      0};
    tbl[4] = '{1'b0, 2'b00, 9'h0,  64'h0,         9'h0, 64'h0,    1'b0, 9'h2,  64'h2222,      0};
    tbl[5] = '{1'b0, 2'b01, 9'h5,  64'hDEADBEEF,  9'h0, 64'h0,    1'b0, 9'h2,  64'h2222,      1};
    tbl[6] = '{1'b0, 2'b00, 9'h0,  64'h0,         9'h0, 64'h0,    1'b1, 9'h5,  64'hDEADBEEF,  0};
    tbl[7] = '{1'b0, 2'b00, 9'h0,  64'h0,         9'h0, 64'h0,    1'b0, 9'h5,  64'hDEADBEEF,  0};
    tbl[8] = '{1'b1, 2'b01, 9'h7,  64'h77,        9'h0, 64'h0,    1'b0, 9'h0,  64'h0,         0};
    tbl[9] = '{1'b0, 2'b00, 9'h0,  64'h0,         9'h0, 64'h0,    1'b0, 9'h0,  64'h0,         0};
    rr_exp = '{9'h10, 9'h20, 9'h11, 9'h21, 9'h12, 9'h22, 9'h13, 9'h23,
               9'h14, 9'h15, 9'h16, 9'h17};

    m_valid = 1'b0; m_tid = '0; m_data = '0; m_ovf = '0; m_rr = 0; m_pend = 0;
    reset = 1'b1;
    drive(2'b00, 9'h0, 64'h0, 9'h0, 64'h0);
    step();
    step();

    // Table vectors.
    for (int r = 0; r < 10; r++) begin
      reset = tbl[r].rst;
      drive(tbl[r].v, tbl[r].t0, tbl[r].d0, tbl[r].t1, tbl[r].d1);
      step();
      chk($sformatf("tbl%0d_valid", r),   64'(c2Tx_mmioRdValid), 64'(tbl[r].ev));
      chk($sformatf("tbl%0d_tid", r),     64'(c2Tx_tid),         64'(tbl[r].et));
      chk($sformatf("tbl%0d_data", r),    c2Tx_data,             tbl[r].ed);
      chk($sformatf("tbl%0d_pending", r), 64'(rsp_pending),      64'(tbl[r].ep));
      $display("vec %0d: valid=%0d tid=%0h data=%0h pending=%0d", r,
               c2Tx_mmioRdValid, c2Tx_tid, c2Tx_data, rsp_pending);
    end

    // Round-robin fairness: 8 from source 0, 4 from source 1, same start.
    reset = 1'b1; drive(2'b00, 9'h0, 64'h0, 9'h0, 64'h0); step();
    reset = 1'b0;
    obs.delete();
    for (int c = 0; c < 8; c++) begin
      rv = {(c < 4) ? 1'b1 : 1'b0, 1'b1};
      drive(rv, 9'(16 + c), 64'(c), 9'(32 + c), 64'(100 + c));
      step();
    end
    drive(2'b00, 9'h0, 64'h0, 9'h0, 64'h0);
    for (int c = 0; c < 8; c++) step();
    chk("rr_count", 64'(obs.size()), 64'd12);
    for (int i = 0; i < 12; i++) begin
      if (i < obs.size()) chk($sformatf("rr_order%0d", i), 64'(obs[i]), 64'(rr_exp[i]));
    end
    $display("rr: %0d responses", obs.size());

    // Both sources saturate: FIFOs fill, drops are flagged, and a full FIFO
    // that is popped still accepts its write so occupancy stays at depth.
    reset = 1'b1; step(); reset = 1'b0;
    for (int c = 0; c < 200; c++) begin
      drive(2'b11, 9'(c), {$urandom, $urandom}, 9'(c + 256), {$urandom, $urandom});
      step();
      if (c >= 196) chk("full_pop_pending", 64'(rsp_pending), 64'(N*D));
    end
    chk("ovf_both", 64'(fifo_overflow), 64'd3);
    drive(2'b00, 9'h0, 64'h0, 9'h0, 64'h0);
    for (int c = 0; c < 140; c++) step();
    chk("drain_pending", 64'(rsp_pending), 64'd0);
    chk("ovf_sticky", 64'(fifo_overflow), 64'd3);
    $display("saturate: ovf=%b pending=%0d", fifo_overflow, rsp_pending);

    // Reset mid-operation: queued entries vanish, new response at min latency.
    for (int c = 0; c < 5; c++) begin
      drive(2'b11, 9'(c), 64'(c), 9'(c + 8), 64'(c + 8));
      step();
    end
    reset = 1'b1; drive(2'b00, 9'h0, 64'h0, 9'h0, 64'h0); step();
    reset = 1'b0;
    chk("rst_pending", 64'(rsp_pending), 64'd0);
    chk("rst_ovf", 64'(fifo_overflow), 64'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rst_no_valid", 64'(c2Tx_mmioRdValid), 64'd0);
    end
    drive(2'b10, 9'h0, 64'h0, 9'h1AB, 64'hCAFE);
    step();
    chk("post_rst_t1", 64'(c2Tx_mmioRdValid), 64'd0);
    drive(2'b00, 9'h0, 64'h0, 9'h0, 64'h0);
    step();
    chk("post_rst_valid", 64'(c2Tx_mmioRdValid), 64'd1);
    chk("post_rst_tid", 64'(c2Tx_tid), 64'h1AB);
    chk("post_rst_data", c2Tx_data, 64'hCAFE);
    $display("reset mid-op: tid=%0h data=%0h", c2Tx_tid, c2Tx_data);

    // Random traffic with varying density and occasional resets.
    dens = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) dens = $urandom_range(20, 95);
      reset = ($urandom_range(0, 399) == 0);
      for (int i = 0; i < N; i++) rv[i] = ($urandom_range(0, 99) < dens);
      drive(rv, 9'($urandom), {$urandom, $urandom}, 9'($urandom), {$urandom, $urandom});
      step();
    end
    $display("random: pending=%0d ovf=%b", rsp_pending, fifo_overflow);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
